abr_prim_sparse_fsm_checker: RTL and testbench
==============================================

Name: abr_prim_sparse_fsm_checker

Overview:
Consumer-side monitor for sparse-encoded FSM state registers. It watches the registered state bus driven by a sparse FSM flop and decodes it against the legal encoding list. It flags invalid encodings and disallowed transitions, latches a sticky fatal error and counts events. Each new error event is escalated through a four-phase req/ack alert handshake to the block's alert sender.

Parameters:
Width, 8, bit width of the monitored state encoding.
NumStates, 4, number of legal encodings.
StateList, {8'h69,8'h96,8'hC5,8'h3A}, packed NumStates x Width array; entry i is the encoding of state index i.
TransMask, ring 0->1->2->3->0 plus self-loops, packed NumStates x NumStates bits; bit [p*NumStates+c]=1 allows the transition p->c.
ResetIdx, 0, state index assumed after reset.
ErrCntWidth, 8, width of the saturating error counter.

Ports:
clk_i  input  1  clock.
rst_i  input  1  reset; synchronous, active-high.
state_i  input  Width  monitored state encoding.
state_vld_i  input  1  state_i is sampled only when high.
clr_err_i  input  1  clears the sticky error, cause, counter and pending flag.
alert_ack_i  input  1  acknowledge from the alert sender.
alert_req_o  output  1  alert request.
fatal_err_o  output  1  sticky fatal error.
err_cause_o  output  2  sticky cause bits: [0] invalid encoding, [1] illegal transition.
err_cnt_o  output  ErrCntWidth  saturating count of error events.
prev_idx_o  output  $clog2(NumStates)  last legal state index.

Behaviour:
- Reset values: alert_req_o=0, fatal_err_o=0, err_cause_o=0, err_cnt_o=0, prev_idx_o=ResetIdx, alert FSM=Idle, pending=0.
- Decode is combinational: state_i is compared against every StateList entry to give a one-hot match.
  - No match: invalid-encoding event.
  - Match c with TransMask[prev*NumStates+c]=0: illegal-transition event.
- prev_idx update:
  - Updates to c on any matching sample, including an illegal transition.
  - Holds its value on an invalid encoding.
  - No updates or events while state_vld_i=0.
- Latency: the event is visible on fatal_err_o, err_cause_o and err_cnt_o 1 cycle after the offending sample.
- err_cnt_o increments by 1 per event cycle and saturates at all-ones.
- clr_err_i zeroes fatal_err_o, err_cause_o, err_cnt_o and pending. If an event occurs in the same cycle, the set wins: fatal=1, cause is that event's bit only, cnt=1.
- Alert FSM (sparse-encoded; states Idle, Req, WaitAckLow):
  - Idle -> Req on an event or pending; alert_req_o=1 in Req.
  - Req -> WaitAckLow when alert_ack_i=1; alert_req_o=0 from that cycle on.
  - WaitAckLow -> Idle when alert_ack_i=0.
  - Events arriving in Req or WaitAckLow set pending. Pending re-fires one Idle cycle after the handshake completes, then clears.
  - clr_err_i does not abort an in-flight handshake.
- Alert FSM self-protection: its state register is an abr_prim_sparse_fsm_flop instance. An invalid alert-FSM encoding sets fatal_err_o and both cause bits, and forces the FSM to Req.
- rst_i mid-handshake returns every register to its reset value on the next edge; alert_req_o drops with no ack required.

Optional Feature:
ABR_SPARSE_FSM_CHK_PIPE_EN:
- Defined: an input register stage captures state_i and state_vld_i. Decode runs on the registered copy, so event-to-output latency is 2 cycles, for timing closure on wide encodings.
- Undefined: latency is 1 cycle as described above.
- Register and handshake semantics are otherwise identical in both builds.

Decomposition:
- abr_prim_sparse_fsm_chk_pkg holds:
  - the alert FSM enum, with Hamming distance >=3 between encodings;
  - the cause bit index constants;
  - the function that derives the default TransMask ring.
- One sub-module: abr_prim_sparse_fsm_chk_dec, the combinational one-hot decoder plus transition lookup. It is reused by the pipelined and unpipelined paths.

Test Plan:
- Legal walk: samples 3A,C5,96,69,3A with vld=1 -> no event; prev_idx_o reads 0,1,2,3,0; fatal=0, cnt=0.
- Invalid encoding: 3A then 8'h00 -> one cycle later fatal=1, cause=2'b01, cnt=1, prev_idx_o=0. Then hold ack=0 for 5 cycles -> alert_req_o stays 1.
- Illegal transition: 3A then 96 -> cause=2'b10, cnt=1, prev_idx_o=2. Then ack pulse 1 then 0 -> FSM goes Req->WaitAckLow->Idle and alert_req_o=0.
- Pending re-fire: an event while in Req -> after ack returns low, alert_req_o reasserts 1 cycle later.
- Saturation and clear: ErrCntWidth=2, drive 5 consecutive bad samples -> cnt=3. Then clr_err_i=1 together with a bad sample -> fatal=1, cnt=1.
- Reset mid-handshake: alert_req_o=1, assert rst_i one cycle -> all outputs at reset values next cycle. With PIPE_EN defined, repeat the invalid-encoding test -> response appears 2 cycles after the sample.

Source files
------------

// File: rtl/abr_prim_sparse_fsm_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : abr_prim_sparse_fsm_chk_pkg
// Brief    : Shared types and constants for the sparse FSM checker.
// Revision : 1.0 - initial release
// ============================================================================
package abr_prim_sparse_fsm_chk_pkg;

  localparam int c_max_states = 16;
  localparam int c_alert_state_width = 5;

  // Encodings are pairwise at Hamming distance >= 3.
  typedef enum logic [c_alert_state_width-1:0] {
    AlertIdle       = 5'b01011,
    AlertReq        = 5'b10110,
    AlertWaitAckLow = 5'b11101
  } alert_state_e;

  localparam int c_cause_invalid = 0;
  localparam int c_cause_trans   = 1;
  localparam int c_num_causes    = 2;

  function automatic logic [c_max_states*c_max_states-1:0] ring_trans_mask(input int n);
    logic [c_max_states*c_max_states-1:0] mask;
    mask = '0;
    for (int p = 0; p < n; p++) begin
      mask[p*n + p]           = 1'b1;
      mask[p*n + ((p+1) % n)] = 1'b1;
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/abr_prim_sparse_fsm_chk_dec.sv
`default_nettype none
// ============================================================================
// Module   : abr_prim_sparse_fsm_chk_dec
// Brief    : One-hot decode of a sparse state and transition-mask lookup.
// Revision : 1.0 - initial release
// ============================================================================
module abr_prim_sparse_fsm_chk_dec #(
  parameter int                               Width     = 8,
  parameter int                               NumStates = 4,
  parameter int                               IdxWidth  = $clog2(NumStates),
  parameter logic [NumStates*Width-1:0]       StateList = '0,
  parameter logic [NumStates*NumStates-1:0]   TransMask = '1
) (
  input  logic [Width-1:0]    state_i,
  input  logic [IdxWidth-1:0] prev_idx_i,
  output logic                match_o,
  output logic [IdxWidth-1:0] match_idx_o,
  output logic                trans_ok_o
);

  localparam int c_tidx_width = $clog2(NumStates*NumStates);

  logic [NumStates-1:0]    w_onehot;
  logic [c_tidx_width-1:0] w_tidx;

  for (genvar i = 0; i < NumStates; i++) begin : g_match
    assign w_onehot[i] = (state_i == StateList[i*Width +: Width]);
  end

  always_comb begin
    match_idx_o = '0;
    for (int i = 0; i < NumStates; i++) begin
      if (w_onehot[i]) begin
        match_idx_o = IdxWidth'(i);
      end
    end
  end

  assign match_o    = |w_onehot;
  assign w_tidx     = c_tidx_width'(prev_idx_i) * c_tidx_width'(NumStates)
                    + c_tidx_width'(match_idx_o);
  assign trans_ok_o = TransMask[w_tidx];

endmodule
`default_nettype wire

// File: rtl/abr_prim_sparse_fsm_flop.sv
`default_nettype none
// ============================================================================
// Module   : abr_prim_sparse_fsm_flop
// Brief    : State register for a sparse-encoded FSM.
// Revision : 1.0 - initial release
// ============================================================================
module abr_prim_sparse_fsm_flop #(
  parameter int               Width      = 5,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] state_i,
  output logic [Width-1:0] state_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_o <= ResetValue;
    end else begin
      state_o <= state_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/abr_prim_sparse_fsm_checker.sv
`default_nettype none
// ============================================================================
// Module   : abr_prim_sparse_fsm_checker
// Brief    : Monitors a sparse FSM state bus, latches errors, raises alerts.
//            Build option: ABR_SPARSE_FSM_CHK_PIPE_EN adds an input stage.
// Revision : 1.0 - initial release
// ============================================================================
module abr_prim_sparse_fsm_checker
  import abr_prim_sparse_fsm_chk_pkg::*;
#(
  parameter int                             Width       = 8,
  parameter int                             NumStates   = 4,
  parameter logic [NumStates*Width-1:0]     StateList   = {8'h69, 8'h96, 8'hC5, 8'h3A},
  parameter logic [NumStates*NumStates-1:0] TransMask   =
      (NumStates*NumStates)'(ring_trans_mask(NumStates)),
  parameter int                             ResetIdx    = 0,
  parameter int                             ErrCntWidth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [Width-1:0]             state_i,
  input  logic                         state_vld_i,
  input  logic                         clr_err_i,
  input  logic                         alert_ack_i,
  output logic                         alert_req_o,
  output logic                         fatal_err_o,
  output logic [c_num_causes-1:0]      err_cause_o,
  output logic [ErrCntWidth-1:0]       err_cnt_o,
  output logic [$clog2(NumStates)-1:0] prev_idx_o
);

  localparam int c_idx_width = $clog2(NumStates);

  logic [Width-1:0]        w_state;
  logic                    w_vld;
  logic                    w_match;
  logic [c_idx_width-1:0]  w_match_idx;
  logic                    w_trans_ok;
  logic                    w_inv_evt;
  logic                    w_trans_evt;
  logic                    w_evt;
  logic                    w_err_evt;
  logic                    w_fsm_inv;
  logic                    w_fire;
  logic                    w_pend_set;
  logic [c_num_causes-1:0] w_cause_set;
  logic [c_alert_state_width-1:0] w_fsm_raw_q;
  alert_state_e            w_fsm_q;
  alert_state_e            w_fsm_d;

  logic                    r_pending;

`ifdef ABR_SPARSE_FSM_CHK_PIPE_EN
  logic [Width-1:0] r_state_q;
  logic             r_vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= '0;
      r_vld_q   <= 1'b0;
    end else begin
      r_state_q <= state_i;
      r_vld_q   <= state_vld_i;
    end
  end

  assign w_state = r_state_q;
  assign w_vld   = r_vld_q;
`else
  assign w_state = state_i;
  assign w_vld   = state_vld_i;
`endif

  abr_prim_sparse_fsm_chk_dec #(
    .Width     (Width),
    .NumStates (NumStates),
    .IdxWidth  (c_idx_width),
    .StateList (StateList),
    .TransMask (TransMask)
  ) u_dec (
    .state_i     (w_state),
    .prev_idx_i  (prev_idx_o),
    .match_o     (w_match),
    .match_idx_o (w_match_idx),
    .trans_ok_o  (w_trans_ok)
  );

  assign w_inv_evt   = w_vld & ~w_match;
  assign w_trans_evt = w_vld & w_match & ~w_trans_ok;
  assign w_evt       = w_inv_evt | w_trans_evt;

  abr_prim_sparse_fsm_flop #(
    .Width      (c_alert_state_width),
    .ResetValue (AlertIdle)
  ) u_alert_state_flop (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .state_i (w_fsm_d),
    .state_o (w_fsm_raw_q)
  );

  assign w_fsm_q = alert_state_e'(w_fsm_raw_q);

  always_comb begin
    w_fsm_d   = w_fsm_q;
    w_fsm_inv = 1'b0;
    w_fire    = 1'b0;
    case (w_fsm_q)
      AlertIdle: begin
        if (w_evt || r_pending) begin
          w_fsm_d = AlertReq;
          w_fire  = 1'b1;
        end
      end
      AlertReq: begin
        if (alert_ack_i) w_fsm_d = AlertWaitAckLow;
      end
      AlertWaitAckLow: begin
        if (!alert_ack_i) w_fsm_d = AlertIdle;
      end
      default: begin
        // Corrupted handshake state: re-raise the alert rather than go quiet.
        w_fsm_d   = AlertReq;
        w_fsm_inv = 1'b1;
      end
    endcase
  end

  assign w_pend_set  = w_evt & (w_fsm_q != AlertIdle);
  assign w_err_evt   = w_evt | w_fsm_inv;
  assign w_cause_set = {w_trans_evt | w_fsm_inv, w_inv_evt | w_fsm_inv};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alert_req_o <= 1'b0;
      fatal_err_o <= 1'b0;
      err_cause_o <= '0;
      err_cnt_o   <= '0;
      prev_idx_o  <= c_idx_width'(ResetIdx);
      r_pending   <= 1'b0;
    end else begin
      alert_req_o <= (w_fsm_d == AlertReq);
      r_pending   <= w_pend_set | (r_pending & ~clr_err_i & ~w_fire);
      if (w_vld && w_match) begin
        prev_idx_o <= w_match_idx;
      end
      // A coincident event overrides the clear.
      if (clr_err_i) begin
        fatal_err_o <= w_err_evt;
        err_cause_o <= w_cause_set;
        err_cnt_o   <= w_evt ? ErrCntWidth'(1) : '0;
      end else begin
        fatal_err_o <= fatal_err_o | w_err_evt;
        err_cause_o <= err_cause_o | w_cause_set;
        if (w_evt && !(&err_cnt_o)) begin
          err_cnt_o <= err_cnt_o + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_abr_prim_sparse_fsm_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_abr_prim_sparse_fsm_checker
// Brief    : Directed self-checking bench for abr_prim_sparse_fsm_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_abr_prim_sparse_fsm_checker;

`ifdef ABR_SPARSE_FSM_CHK_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] state_i;
  logic       state_vld_i;
  logic       clr_err_i;
  logic       alert_ack_i;
  logic       alert_req_o;
  logic       fatal_err_o;
  logic [1:0] err_cause_o;
  logic [1:0] err_cnt_o;
  logic [1:0] prev_idx_o;

  int n_cmp = 0;
  int n_err = 0;

  abr_prim_sparse_fsm_checker #(
    .ErrCntWidth (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .state_i     (state_i),
    .state_vld_i (state_vld_i),
    .clr_err_i   (clr_err_i),
    .alert_ack_i (alert_ack_i),
    .alert_req_o (alert_req_o),
    .fatal_err_o (fatal_err_o),
    .err_cause_o (err_cause_o),
    .err_cnt_o   (err_cnt_o),
    .prev_idx_o  (prev_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic settle();
    repeat (LAT-1) @(negedge clk_i);
  endtask

  task automatic drive(input logic [7:0] s);
    state_i     = s;
    state_vld_i = 1'b1;
    @(negedge clk_i);
    state_vld_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  logic [7:0] walk_s [5] = '{8'h3A, 8'hC5, 8'h96, 8'h69, 8'h3A};
  logic [1:0] walk_p [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    state_i = '0; state_vld_i = 1'b0; clr_err_i = 1'b0; alert_ack_i = 1'b0;
    do_reset();
    check_eq("rst_req",   alert_req_o, 0);
    check_eq("rst_fatal", fatal_err_o, 0);
    check_eq("rst_cause", err_cause_o, 0);
    check_eq("rst_cnt",   err_cnt_o,   0);
    check_eq("rst_prev",  prev_idx_o,  0);

    // Legal ring walk
    for (int i = 0; i < 5; i++) begin
      drive(walk_s[i]);
      settle();
      check_eq($sformatf("walk_prev%0d", i), prev_idx_o, walk_p[i]);
    end
    check_eq("walk_fatal", fatal_err_o, 0);
    check_eq("walk_cnt",   err_cnt_o,   0);
    check_eq("walk_req",   alert_req_o, 0);

    // Invalid encoding, then a long un-acked request, then handshake and clear
    drive(8'h3A);
    drive(8'h00);
    check_eq("inv_latency", fatal_err_o, (LAT == 1) ? 1 : 0);
    settle();
    check_eq("inv_fatal", fatal_err_o, 1);
    check_eq("inv_cause", err_cause_o, 2'b01);
    check_eq("inv_cnt",   err_cnt_o,   1);
    check_eq("inv_prev",  prev_idx_o,  0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("inv_hold_req%0d", i), alert_req_o, 1);
    end
    alert_ack_i = 1'b1; step();
    check_eq("inv_ack_req", alert_req_o, 0);
    alert_ack_i = 1'b0; step(); step();
    check_eq("inv_idle_req", alert_req_o, 0);
    clr_err_i = 1'b1; step(); clr_err_i = 1'b0;
    check_eq("clr_fatal", fatal_err_o, 0);
    check_eq("clr_cause", err_cause_o, 0);
    check_eq("clr_cnt",   err_cnt_o,   0);

    // Illegal transition 0 -> 2
    do_reset();
    drive(8'h3A);
    drive(8'h96);
    settle();
    check_eq("tr_fatal", fatal_err_o, 1);
    check_eq("tr_cause", err_cause_o, 2'b10);
    check_eq("tr_cnt",   err_cnt_o,   1);
    check_eq("tr_prev",  prev_idx_o,  2);
    check_eq("tr_req",   alert_req_o, 1);
    alert_ack_i = 1'b1; step();
    check_eq("tr_wait_req", alert_req_o, 0);
    alert_ack_i = 1'b0; step();
    check_eq("tr_idle_req", alert_req_o, 0);
    step();
    check_eq("tr_nopend_req", alert_req_o, 0);

    // Event during Req re-fires after the handshake completes
    do_reset();
    drive(8'h00);
    settle();
    check_eq("pend_req0", alert_req_o, 1);
    drive(8'h00);
    settle();
    check_eq("pend_cnt", err_cnt_o, 2);
    alert_ack_i = 1'b1; step();
    check_eq("pend_wait_req", alert_req_o, 0);
    alert_ack_i = 1'b0; step();
    check_eq("pend_idle_req", alert_req_o, 0);
    step();
    check_eq("pend_refire_req", alert_req_o, 1);
    alert_ack_i = 1'b1; step();
    alert_ack_i = 1'b0; step(); step();
    check_eq("pend_done_req", alert_req_o, 0);

    // Counter saturation, then clear coinciding with an event
    do_reset();
    for (int i = 0; i < 5; i++) drive(8'h00);
    settle();
    check_eq("sat_cnt",   err_cnt_o,   3);
    check_eq("sat_cause", err_cause_o, 2'b01);
    state_i     = 8'h96;
    state_vld_i = 1'b1;
    clr_err_i   = (LAT == 1);
    step();
    state_vld_i = 1'b0;
    clr_err_i   = (LAT == 2);
    settle();
    clr_err_i   = 1'b0;
    check_eq("clrset_fatal", fatal_err_o, 1);
    check_eq("clrset_cause", err_cause_o, 2'b10);
    check_eq("clrset_cnt",   err_cnt_o,   1);
    check_eq("clrset_prev",  prev_idx_o,  2);

    // Reset while a request is outstanding
    check_eq("mid_req", alert_req_o, 1);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    check_eq("mid_rst_req",   alert_req_o, 0);
    check_eq("mid_rst_fatal", fatal_err_o, 0);
    check_eq("mid_rst_cause", err_cause_o, 0);
    check_eq("mid_rst_cnt",   err_cnt_o,   0);
    check_eq("mid_rst_prev",  prev_idx_o,  0);
    step();
    check_eq("mid_rst_stays", alert_req_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
